// File: rtl/voter_pkg.sv
// Shared types and constants for the ballot collector and the 4-voter majority decoder.
package voter_pkg;

  localparam int N_VOTERS = 4;

  localparam logic [2:0] RES_REJECT = 3'b100;
  localparam logic [2:0] RES_TIE    = 3'b010;
  localparam logic [2:0] RES_PASS   = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OPEN,
    ST_SETTLE,
    ST_DONE
  } state_t;

  function automatic logic res_onehot(input logic [2:0] r);
    return (r == RES_REJECT) || (r == RES_TIE) || (r == RES_PASS);
  endfunction

endpackage

// File: rtl/ballot_collector_if.sv
// Button/decoder side bus of the ballot collector; slave = collector, master = its environment.
interface ballot_collector_if;
  import voter_pkg::*;

  logic                start;
  logic [N_VOTERS-1:0] yes;
  logic [N_VOTERS-1:0] no;
  logic [N_VOTERS-1:0] ballot;
  logic                ballot_valid;
  logic [N_VOTERS-1:0] voted;
  logic                busy;
  logic [2:0]          result;
  logic [2:0]          result_q;
  logic                done;
  logic                err;

  modport master (
    output start, yes, no, result,
    input  ballot, ballot_valid, voted, busy, result_q, done, err
  );

  modport slave (
    input  start, yes, no, result,
    output ballot, ballot_valid, voted, busy, result_q, done, err
  );

endinterface

// File: rtl/voter_lane.sv
// One voter's ballot/voted bits. VOTE_CHANGE_EN lets a recorded vote be overwritten while open.
module voter_lane (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic yes,
  input  logic no,
  output logic ballot,
  output logic voted,
  output logic voted_nxt
);

  logic press_yes, press_no, take;

  // Simultaneous yes and no is a conflict and records nothing.
  assign press_yes = yes & ~no;
  assign press_no  = no & ~yes;

`ifdef VOTE_CHANGE_EN
  assign take = press_yes | press_no;
`else
  assign take = ~voted & (press_yes | press_no);
`endif

  // Voted state as of the coming edge, so the top can close on the completing vote.
  assign voted_nxt = voted | (en & take);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ballot <= 1'b0;
      voted  <= 1'b0;
    end else if (clr) begin
      ballot <= 1'b0;
      voted  <= 1'b0;
    end else if (en && take) begin
      ballot <= press_yes;
      voted  <= 1'b1;
    end
  end

endmodule

// File: rtl/window_timer.sv
// Loadable down-counter timing the voting window; zero flags the last open cycle.
module window_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       count <= '0;
    else if (load) count <= load_val;
    else if (dec)  count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ballot_collector.sv
// Runs one voting session and latches the decoder verdict.
// Build option: VOTE_CHANGE_EN (votes may change while open; close only on timeout).
module ballot_collector
  import voter_pkg::*;
#(
  parameter int WINDOW_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input logic              clk,
  input logic              rst,
  ballot_collector_if.slave bus
);

  state_t              state;
  logic                busy_r, bv_r, done_r, err_r;
  logic [2:0]          rq_r;
  logic                accept, open_st, timer_zero, close;
  logic [N_VOTERS-1:0] yes_v, no_v, ballot_v, voted_v, voted_nxt_v;

  assign accept  = (state == ST_IDLE) & bus.start;
  assign open_st = (state == ST_OPEN);
  assign yes_v   = bus.yes;
  assign no_v    = bus.no;

  window_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (CNT_W'(WINDOW_CYCLES - 1)),
    .dec      (open_st & ~timer_zero),
    .zero     (timer_zero)
  );

  voter_lane u_lane [N_VOTERS-1:0] (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept),
    .en        (open_st),
    .yes       (yes_v),
    .no        (no_v),
    .ballot    (ballot_v),
    .voted     (voted_v),
    .voted_nxt (voted_nxt_v)
  );

`ifdef VOTE_CHANGE_EN
  assign close = timer_zero;
`else
  assign close = timer_zero | (&voted_nxt_v);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      busy_r <= 1'b0;
      bv_r   <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
      rq_r   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state  <= ST_OPEN;
            busy_r <= 1'b1;
          end
        end
        ST_OPEN: begin
          if (close) begin
            state <= ST_SETTLE;
            bv_r  <= 1'b1;
          end
        end
        ST_SETTLE: begin
          bv_r   <= 1'b0;
          rq_r   <= bus.result;
          err_r  <= ~res_onehot(bus.result);
          done_r <= 1'b1;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ballot       = ballot_v;
  assign bus.voted        = voted_v;
  assign bus.ballot_valid = bv_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.result_q     = rq_r;
  assign bus.err          = err_r;

endmodule

// File: tb/tb_ballot_collector.sv
// Scenario bench for ballot_collector; expected session outcomes go through a scoreboard queue.
module tb_ballot_collector;
  import voter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ballot_collector_if bus();

  ballot_collector #(.WINDOW_CYCLES(16), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] ballot;
    logic [3:0] voted;
    logic [2:0] rq;
    logic       err;
    int         open_n;
  } exp_t;

  exp_t sb[$];

  // Observed values of one session close, filled by close_session.
  int         o_n;
  logic [3:0] o_b, o_v;
  logic       o_bva, o_d1, o_d2, o_busy2, o_e;
  logic [2:0] o_rq;
  bit         o_to;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_session();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Waits (bounded) for ballot_valid, answers with res, follows through DONE into IDLE.
  task automatic close_session(input logic [2:0] res, input bit start_in_done);
    o_n = 0; o_to = 1; o_b = 'x; o_v = 'x; o_bva = 'x; o_d1 = 'x; o_d2 = 'x;
    o_busy2 = 'x; o_rq = 'x; o_e = 'x;
    for (int i = 0; i < 64; i++) begin
      tick();
      bus.yes = '0;
      bus.no  = '0;
      o_n++;
      if (bus.ballot_valid) begin
        o_to = 0;
        break;
      end
    end
    if (o_to) return;
    o_b = bus.ballot;
    o_v = bus.voted;
    bus.result = res;
    tick();
    o_d1  = bus.done;
    o_bva = bus.ballot_valid;
    o_rq  = bus.result_q;
    o_e   = bus.err;
    bus.result = '0;
    if (start_in_done) bus.start = 1'b1;
    tick();
    o_d2    = bus.done;
    o_busy2 = bus.busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 0; bus.yes = '0; bus.no = '0; bus.result = '0;
    tick(); tick();
    n_chk++;
    if ({bus.busy, bus.ballot_valid, bus.done, bus.err} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b exp 0000", {bus.busy, bus.ballot_valid, bus.done, bus.err});
    end
    n_chk++;
    if ({bus.ballot, bus.voted, bus.result_q} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_vectors got %b/%b/%b exp 0", bus.ballot, bus.voted, bus.result_q);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_early_close();
    exp_t x;
    sb.push_back('{4'b0111, 4'b1111, RES_PASS, 1'b0, 1});
    start_session();
    n_chk++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL early_busy got %b exp 1", bus.busy); end
    bus.yes = 4'b0111; bus.no = 4'b1000;
    close_session(RES_PASS, 0);
    x = sb.pop_front();
    n_chk++; if (o_to) begin n_fail++; $display("FAIL early_timeout got no ballot_valid exp ballot_valid"); end
    n_chk++; if (o_n !== x.open_n) begin n_fail++; $display("FAIL early_open_cycles got %0d exp %0d", o_n, x.open_n); end
    n_chk++; if (o_b !== x.ballot) begin n_fail++; $display("FAIL early_ballot got %b exp %b", o_b, x.ballot); end
    n_chk++; if (o_v !== x.voted) begin n_fail++; $display("FAIL early_voted got %b exp %b", o_v, x.voted); end
    n_chk++; if (o_bva !== 1'b0) begin n_fail++; $display("FAIL early_valid_width got %b exp 0", o_bva); end
    n_chk++; if ({o_d1, o_d2} !== 2'b10) begin n_fail++; $display("FAIL early_done_pulse got %b exp 10", {o_d1, o_d2}); end
    n_chk++; if (o_busy2 !== 1'b0) begin n_fail++; $display("FAIL early_busy_end got %b exp 0", o_busy2); end
    n_chk++; if (o_rq !== x.rq) begin n_fail++; $display("FAIL early_result_q got %b exp %b", o_rq, x.rq); end
    n_chk++; if (o_e !== x.err) begin n_fail++; $display("FAIL early_err got %b exp %b", o_e, x.err); end
  endtask

  task automatic test_timeout();
    exp_t x;
    sb.push_back('{4'b0001, 4'b0001, RES_REJECT, 1'b0, 16});
    start_session();
    bus.yes = 4'b0001;
    close_session(RES_REJECT, 0);
    x = sb.pop_front();
    n_chk++; if (o_to) begin n_fail++; $display("FAIL tmo_timeout got no ballot_valid exp ballot_valid"); end
    n_chk++; if (o_n !== x.open_n) begin n_fail++; $display("FAIL tmo_open_cycles got %0d exp %0d", o_n, x.open_n); end
    n_chk++; if (o_b !== x.ballot) begin n_fail++; $display("FAIL tmo_ballot got %b exp %b", o_b, x.ballot); end
    n_chk++; if (o_v !== x.voted) begin n_fail++; $display("FAIL tmo_voted got %b exp %b", o_v, x.voted); end
    n_chk++; if (o_rq !== x.rq) begin n_fail++; $display("FAIL tmo_result_q got %b exp %b", o_rq, x.rq); end
    n_chk++; if ({o_d1, o_d2} !== 2'b10) begin n_fail++; $display("FAIL tmo_done_pulse got %b exp 10", {o_d1, o_d2}); end
  endtask

  task automatic test_conflict_lock();
    exp_t x;
`ifdef VOTE_CHANGE_EN
    sb.push_back('{4'b1101, 4'b1111, RES_PASS, 1'b0, 13});
`else
    sb.push_back('{4'b1001, 4'b1111, RES_TIE, 1'b0, 1});
`endif
    start_session();
    bus.yes = 4'b0101; bus.no = 4'b0110;
    tick();
    n_chk++; if (bus.voted !== 4'b0011) begin n_fail++; $display("FAIL conf_voted got %b exp 0011", bus.voted); end
    bus.yes = 4'b0000; bus.no = 4'b0100;
    tick();
    n_chk++; if ({bus.voted, bus.ballot} !== 8'b0111_0001) begin n_fail++; $display("FAIL conf_no_rec got %b/%b exp 0111/0001", bus.voted, bus.ballot); end
    bus.yes = 4'b0100; bus.no = 4'b0000;
    tick();
`ifdef VOTE_CHANGE_EN
    n_chk++; if (bus.ballot !== 4'b0101) begin n_fail++; $display("FAIL conf_change got %b exp 0101", bus.ballot); end
`else
    n_chk++; if (bus.ballot !== 4'b0001) begin n_fail++; $display("FAIL conf_lock got %b exp 0001", bus.ballot); end
`endif
    bus.yes = 4'b1000; bus.no = 4'b0000;
    close_session(sb[0].rq, 0);
    x = sb.pop_front();
    n_chk++; if (o_n !== x.open_n) begin n_fail++; $display("FAIL conf_open_cycles got %0d exp %0d", o_n, x.open_n); end
    n_chk++; if (o_b !== x.ballot) begin n_fail++; $display("FAIL conf_ballot got %b exp %b", o_b, x.ballot); end
    n_chk++; if (o_v !== x.voted) begin n_fail++; $display("FAIL conf_voted_final got %b exp %b", o_v, x.voted); end
    n_chk++; if (o_rq !== x.rq) begin n_fail++; $display("FAIL conf_result_q got %b exp %b", o_rq, x.rq); end
  endtask

  task automatic test_bad_verdict();
    exp_t x;
    sb.push_back('{4'b1111, 4'b1111, 3'b011, 1'b1, 1});
    start_session();
    bus.yes = 4'b1111;
    close_session(3'b011, 0);
    x = sb.pop_front();
    n_chk++; if (o_b !== x.ballot) begin n_fail++; $display("FAIL bad_ballot got %b exp %b", o_b, x.ballot); end
    n_chk++; if (o_rq !== x.rq) begin n_fail++; $display("FAIL bad_result_q got %b exp %b", o_rq, x.rq); end
    n_chk++; if (o_e !== x.err) begin n_fail++; $display("FAIL bad_err got %b exp %b", o_e, x.err); end
    n_chk++; if (o_d1 !== 1'b1) begin n_fail++; $display("FAIL bad_done got %b exp 1", o_d1); end
  endtask

  task automatic test_reset_mid();
    exp_t x;
    int   dones;
    start_session();
    bus.yes = 4'b0101;
    tick();
    bus.yes = '0;
    n_chk++; if (bus.voted !== 4'b0101) begin n_fail++; $display("FAIL rmid_voted got %b exp 0101", bus.voted); end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({bus.busy, bus.ballot_valid, bus.done, bus.err, bus.ballot, bus.voted, bus.result_q} !== 15'b0) begin
      n_fail++;
      $display("FAIL rmid_async_clear got %b/%b/%b/%b/%b/%b/%b exp all 0", bus.busy, bus.ballot_valid,
               bus.done, bus.err, bus.ballot, bus.voted, bus.result_q);
    end
    tick();
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.done || bus.busy) dones++;
    end
    n_chk++; if (dones !== 0) begin n_fail++; $display("FAIL rmid_no_done got %0d active cycles exp 0", dones); end
    sb.push_back('{4'b0000, 4'b1111, RES_REJECT, 1'b0, 1});
    start_session();
    n_chk++; if ({bus.busy, bus.voted} !== 5'b1_0000) begin n_fail++; $display("FAIL rmid_restart got %b exp 10000", {bus.busy, bus.voted}); end
    bus.no = 4'b1111;
    close_session(RES_REJECT, 0);
    x = sb.pop_front();
    n_chk++; if (o_b !== x.ballot) begin n_fail++; $display("FAIL rmid_ballot got %b exp %b", o_b, x.ballot); end
    n_chk++; if (o_rq !== x.rq) begin n_fail++; $display("FAIL rmid_result_q got %b exp %b", o_rq, x.rq); end
  endtask

  task automatic test_start_ignored();
    exp_t x;
    sb.push_back('{4'b0001, 4'b0001, RES_REJECT, 1'b0, 15});
    start_session();
    bus.start = 1'b1; bus.yes = 4'b0001;
    tick();
    bus.start = 1'b0; bus.yes = '0;
    n_chk++; if ({bus.busy, bus.voted} !== 5'b1_0001) begin n_fail++; $display("FAIL sig_open_start got %b exp 10001", {bus.busy, bus.voted}); end
    close_session(RES_REJECT, 1);
    x = sb.pop_front();
    n_chk++; if (o_n !== x.open_n) begin n_fail++; $display("FAIL sig_open_cycles got %0d exp %0d", o_n, x.open_n); end
    n_chk++; if (o_v !== x.voted) begin n_fail++; $display("FAIL sig_voted got %b exp %b", o_v, x.voted); end
    n_chk++; if (o_busy2 !== 1'b0) begin n_fail++; $display("FAIL sig_done_start got busy %b exp 0", o_busy2); end
    n_chk++; if (bus.ballot !== x.ballot) begin n_fail++; $display("FAIL sig_ballot_hold got %b exp %b", bus.ballot, x.ballot); end
    tick();
    bus.start = 1'b0;
    n_chk++; if ({bus.busy, bus.voted} !== 5'b1_0000) begin n_fail++; $display("FAIL sig_new_session got %b exp 10000", {bus.busy, bus.voted}); end
    sb.push_back('{4'b0000, 4'b1111, RES_REJECT, 1'b0, 1});
    bus.no = 4'b1111;
    close_session(RES_REJECT, 0);
    x = sb.pop_front();
    n_chk++; if (o_n !== x.open_n) begin n_fail++; $display("FAIL sig_new_open got %0d exp %0d", o_n, x.open_n); end
    n_chk++; if (o_b !== x.ballot) begin n_fail++; $display("FAIL sig_new_ballot got %b exp %b", o_b, x.ballot); end
  endtask

  initial begin
    test_reset();
    test_early_close();
    test_timeout();
    test_conflict_lock();
    test_bad_verdict();
    test_reset_mid();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got no end of test exp end before 100000");
    $fatal(1, "watchdog expired");
  end

endmodule
